peak_window_ctrl: RTL and testbench
===================================

Name: peak_window_ctrl

Overview:
Window scheduler and readout arbiter for the per-channel peak detectors in the DDC monitor path. It generates the measurement window from a programmable cycle count and tracks the running unsigned maximum of NUM_CH sample streams. At each window end it snapshots every channel's peak. It then serialises the frame onto a single valid/ready port shared by all channels, so the host/register interface reads one 32-bit word per channel.

Parameters:
NUM_CH, 4, number of monitored channels (2..16)
DW, 32, sample / peak width, unsigned
CW, 18, width of window-period counter
DEF_PERIOD, 150000, period loaded at reset (1 ms at 150 MHz)

Ports:
clk  in  1  system clock
rst  in  1  reset: synchronous, active-high (clock clk)
en  in  1  1 = windows run; 0 = counter and running maxima held at 0
cfg_period  in  CW  window length in cycles, sampled at window start
data_in  in  NUM_CH*DW  channel i at bits [i*DW +: DW], valid every cycle
out_valid  out  1  readout beat valid
out_ready  in  1  consumer accepts beat
out_data  out  DW  peak of channel out_ch
out_ch  out  4  channel index of current beat
out_last  out  1  high on beat for channel NUM_CH-1
out_frame  out  16  window number of the frame being sent
drop_cnt  out  8  saturating count of frames discarded due to backpressure

Behaviour:
- Reset: out_valid=0, out_data=0, out_ch=0, out_last=0, out_frame=0, drop_cnt=0, FSM=IDLE, win counter=0, running maxima=0, period_q=DEF_PERIOD, frame counter=0.
- Window counter: counts 0..period_q-1. Terminal cycle T is cnt==period_q-1.
- period_q loads from cfg_period while en=0 and at every terminal cycle. A mid-window change therefore takes effect on the next window.
- Period clamp: cfg_period<2 is treated as 2.
- Running max: run[i] <= max(run[i], data_i) unsigned, every cycle with en=1.
- At T, snap[i] = max(run[i], data_i): the terminal-cycle sample belongs to the closing window. run[i] <= 0 at T, so the next window starts empty.
- Frame counter increments at every T, wraps at 16 bits. Dropped frames consume a number.
- en=0: counter and run[] forced to 0, no terminal events. The FSM keeps draining any frame in progress. The first cycle with en=1 is cnt=0.
- FSM states:
  - IDLE: out_valid=0. On T, capture snap[] into hold[] and latch out_frame, then go to SEND with idx=0. out_valid=1 at T+1.
  - SEND: out_valid=1, out_data=hold[idx], out_ch=idx, out_last=(idx==NUM_CH-1).
    - While out_ready=0, all outputs stay stable.
    - On accept, idx++. Accept of the last beat returns the FSM to IDLE.
- Terminal event while in SEND, except the last-beat accept cycle: hold[] is not overwritten and the new frame is discarded. drop_cnt increments, saturating at 255.
- Simultaneous last-beat accept and T: no drop. hold[] is reloaded from snap[], and the FSM stays in SEND with idx=0 and the new out_frame.
- rst mid-operation: takes effect the next edge. The in-flight frame is abandoned and all state returns to reset values.
- No combinational path from out_ready to out_valid or out_data.

Decomposition:
- Shared package peak_window_pkg holds:
  - FSM state enum (IDLE, SEND)
  - DW and DEF_PERIOD defaults
  - the minimum-period constant (2)
- One sub-module is natural: win_tick_gen. It contains the period counter, clamp and period_q latch, and outputs a one-cycle terminal strobe.

Test Plan:
1. Basic frame. NUM_CH=4, cfg_period=8, out_ready=1. Stimulus: ch0 ramps 1..8, ch1=5 constant, ch2=0, ch3=0xFFFFFFFF only in cycle 3.
   -> Beats starting T+1: 8, 5, 0, 0xFFFFFFFF; out_ch 0..3; out_last on the 4th beat; out_frame=0.
2. Window boundary. ch0=100 only in the terminal cycle, otherwise 0; next window ch0=1.
   -> Frame 0 reports 100, frame 1 reports 1 (no carry-over).
3. Backpressure. period=8, out_ready=0 for 20 cycles after first out_valid.
   -> Beat 0 held stable; drop_cnt=2; after release, frame 0 completes and the next frame sent has out_frame=3.
4. Simultaneous event. Time out_ready so the last-beat accept lands exactly on T.
   -> drop_cnt unchanged; out_valid stays 1 with out_ch=0 and the incremented out_frame on the next cycle.
5. Period programming. cfg_period changed 8->16 at cnt=3.
   -> Current window still 8 cycles, next 16. cfg_period=0 gives 2-cycle windows.
6. Reset mid-frame. Assert rst during beat 2 of a frame.
   -> Next cycle: out_valid=0, drop_cnt=0, out_frame=0, counter restarts; the first post-reset frame reports only post-reset samples.

Source files
------------

// File: rtl/peak_window_pkg.sv
// Shared types and defaults for the peak-window monitor block.
// Imported by the window tick generator and the readout controller.
package peak_window_pkg;

    typedef enum logic {
        IDLE,
        SEND
    } state_e;

    localparam int PW_DW         = 32;
    localparam int PW_DEF_PERIOD = 150000;
    localparam int MIN_PERIOD    = 2;

endpackage

// File: rtl/peak_window_ctrl_win_tick_gen.sv
// Window period counter with clamped period latch.
// tick_o marks the terminal cycle of each measurement window.
module win_tick_gen
    import peak_window_pkg::*;
#(
    parameter int CW         = 18,
    parameter int DEF_PERIOD = PW_DEF_PERIOD
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  logic [CW-1:0] cfg_period_i,
    output logic          tick_o
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] period_q, period_d;
    logic [CW-1:0] cfg_clamped;
    logic          term;

    assign cfg_clamped = (cfg_period_i < CW'(MIN_PERIOD))
                       ? CW'(MIN_PERIOD) : cfg_period_i;
    assign term   = (cnt_q == period_q - CW'(1));
    assign tick_o = en_i && term;

    // Next count and period: period reloads only between windows.
    always_comb begin
        cnt_d    = cnt_q + CW'(1);
        period_d = period_q;
        if (!en_i) begin
            cnt_d    = '0;
            period_d = cfg_clamped;
        end else if (term) begin
            cnt_d    = '0;
            period_d = cfg_clamped;
        end
    end

    // Counter and period registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            period_q <= CW'(DEF_PERIOD);
        end else begin
            cnt_q    <= cnt_d;
            period_q <= period_d;
        end
    end

endmodule

// File: rtl/peak_window_ctrl.sv
// Per-window peak capture for NUM_CH channels with serial readout.
// One frame is held at a time; frames ending mid-readout are dropped.
module peak_window_ctrl
    import peak_window_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int DW         = PW_DW,
    parameter int CW         = 18,
    parameter int DEF_PERIOD = PW_DEF_PERIOD
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [CW-1:0]        cfg_period,
    input  logic [NUM_CH*DW-1:0] data_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DW-1:0]        out_data,
    output logic [3:0]           out_ch,
    output logic                 out_last,
    output logic [15:0]          out_frame,
    output logic [7:0]           drop_cnt
);

    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic          tick;
    logic [DW-1:0] run_q  [NUM_CH];
    logic [DW-1:0] hold_q [NUM_CH];
    logic [DW-1:0] snap   [NUM_CH];

    state_e        state_q;
    logic [IW-1:0] idx_q;
    logic [IW-1:0] idx_nxt;
    logic          valid_q;
    logic [DW-1:0] data_q;
    logic [3:0]    ch_q;
    logic          last_q;
    logic [15:0]   frame_q;
    logic [15:0]   out_frame_q;
    logic [7:0]    drop_q;

    logic          idx_last;
    logic          last_acc;
    logic          load_go;
    logic          drop_go;

    win_tick_gen #(
        .CW         (CW),
        .DEF_PERIOD (DEF_PERIOD)
    ) u_tick (
        .clk          (clk),
        .rst          (rst),
        .en_i         (en),
        .cfg_period_i (cfg_period),
        .tick_o       (tick)
    );

    // Terminal-cycle sample belongs to the window that is closing.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            snap[i] = (data_in[i*DW +: DW] > run_q[i])
                    ? data_in[i*DW +: DW] : run_q[i];
        end
    end

    // Running maxima, cleared at window end and while disabled.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (rst || !en || tick) begin
                run_q[i] <= '0;
            end else begin
                run_q[i] <= snap[i];
            end
        end
    end

    assign idx_nxt  = idx_q + IW'(1);
    assign idx_last = (idx_q == IW'(NUM_CH - 1));
    assign last_acc = (state_q == SEND) && out_ready && idx_last;
    assign load_go  = tick && ((state_q == IDLE) || last_acc);
    assign drop_go  = tick && (state_q == SEND) && !last_acc;

    // Readout FSM, frame numbering and drop accounting.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            ch_q        <= '0;
            last_q      <= 1'b0;
            frame_q     <= '0;
            out_frame_q <= '0;
            drop_q      <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            if (tick) begin
                frame_q <= frame_q + 16'd1;
            end
            if (drop_go && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end
            if (load_go) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    hold_q[i] <= snap[i];
                end
                state_q     <= SEND;
                out_frame_q <= frame_q;
                idx_q       <= '0;
                valid_q     <= 1'b1;
                data_q      <= snap[0];
                ch_q        <= '0;
                last_q      <= (NUM_CH == 1);
            end else if ((state_q == SEND) && out_ready) begin
                if (idx_last) begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                end else begin
                    idx_q  <= idx_nxt;
                    data_q <= hold_q[idx_nxt];
                    ch_q   <= 4'(idx_nxt);
                    last_q <= (idx_nxt == IW'(NUM_CH - 1));
                end
            end
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_ch    = ch_q;
    assign out_last  = last_q;
    assign out_frame = out_frame_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_peak_window_ctrl.sv
// Directed bench for peak_window_ctrl with a beat scoreboard.
// Expected frames are queued at their terminal cycle and popped per beat.
module tb_peak_window_ctrl;

    localparam int NUM_CH = 4;
    localparam int DW     = 32;
    localparam int CW     = 18;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 en;
    logic [CW-1:0]        cfg_period;
    logic [NUM_CH*DW-1:0] data_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [DW-1:0]        out_data;
    logic [3:0]           out_ch;
    logic                 out_last;
    logic [15:0]          out_frame;
    logic [7:0]           drop_cnt;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  ch;
        logic        last;
        logic [15:0] frame;
    } beat_t;

    beat_t       exp_q[$];
    int          errors   = 0;
    int          checks   = 0;
    int          unstable = 0;
    logic [31:0] d [4];

    always #5 clk = ~clk;

    peak_window_ctrl #(
        .NUM_CH     (NUM_CH),
        .DW         (DW),
        .CW         (CW),
        .DEF_PERIOD (150000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .cfg_period (cfg_period),
        .data_in    (data_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ch     (out_ch),
        .out_last   (out_last),
        .out_frame  (out_frame),
        .drop_cnt   (drop_cnt)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input logic [15:0] f,
                              input logic [31:0] p0, input logic [31:0] p1,
                              input logic [31:0] p2, input logic [31:0] p3,
                              input int n);
        logic [31:0] p [4];
        p = '{p0, p1, p2, p3};
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{data: p[i], ch: 4'(i),
                              last: (i == 3), frame: f});
        end
    endtask

    // Scoreboard monitor: one pop per accepted beat.
    always @(negedge clk) begin
        beat_t e;
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got ch=%0d data=%0h frame=%0d expected no beat",
                         out_ch, out_data, out_frame);
            end else begin
                e = exp_q.pop_front();
                check("beat_data",  out_data,          e.data);
                check("beat_ch",    32'(out_ch),       32'(e.ch));
                check("beat_last",  32'(out_last),     32'(e.last));
                check("beat_frame", 32'(out_frame),    32'(e.frame));
            end
        end
    end

    task automatic drive(input int c);
        d          = '{default: '0};
        en         = 1'b1;
        cfg_period = CW'(8);
        out_ready  = 1'b1;
        rst        = 1'b0;
        if (c <= 7) begin
            d[0] = 32'(c + 1);
            d[1] = 32'd5;
            if (c == 3) d[3] = 32'hFFFF_FFFF;
            if (c == 7) push_frame(0, 8, 5, 0, 32'hFFFF_FFFF, 4);
        end else if (c <= 15) begin
            if (c == 15) begin
                d[0] = 32'd100;
                push_frame(1, 100, 0, 0, 0, 4);
            end
        end else if (c <= 23) begin
            d[0] = 32'd1;
            if (c == 23) push_frame(2, 1, 0, 0, 0, 4);
        end else if (c <= 31) begin
            for (int i = 0; i < 4; i++) d[i] = 32'h30 + 32'(i);
            if (c == 31) push_frame(3, 'h30, 'h31, 'h32, 'h33, 4);
        end else if (c <= 47) begin
            for (int i = 0; i < 4; i++) d[i] = 32'h40 + 32'(i);
        end else if (c <= 55) begin
            for (int i = 0; i < 4; i++) d[i] = 32'h60 + 32'(i);
            if (c == 55) push_frame(6, 'h60, 'h61, 'h62, 'h63, 4);
        end else if (c <= 63) begin
            d[0] = 32'h70 + 32'(c - 56);
            if (c >= 59) cfg_period = CW'(16);
            if (c == 63) push_frame(7, 'h77, 0, 0, 0, 4);
        end else if (c <= 79) begin
            cfg_period = (c >= 70) ? CW'(0) : CW'(16);
            d[0] = 32'h80 + 32'(c - 64);
            if (c == 72) d[1] = 32'h77;
            if (c == 79) push_frame(8, 'h8F, 'h77, 0, 0, 4);
        end else if (c <= 87) begin
            cfg_period = CW'(0);
            d[0] = 32'(c);
            if (c == 83) push_frame(10, 83, 0, 0, 0, 4);
            if (c == 87) push_frame(12, 87, 0, 0, 0, 4);
        end else if (c <= 92) begin
            en = 1'b0;
        end else if (c <= 103) begin
            for (int i = 0; i < 4; i++) d[i] = 32'h999;
            if (c == 100) push_frame(13, 'h999, 'h999, 'h999, 'h999, 2);
            if (c == 103) rst = 1'b1;
        end else if (c == 104) begin
            en = 1'b0;
        end else if (c <= 112) begin
            for (int i = 0; i < 4; i++) d[i] = 32'h11 + 32'(i);
            if (c == 112) push_frame(0, 'h11, 'h12, 'h13, 'h14, 4);
        end else begin
            en = 1'b0;
        end
        if (c >= 32 && c <= 51) out_ready = 1'b0;
        data_in = {d[3], d[2], d[1], d[0]};
    endtask

    task automatic check_cycle(input int c);
        if (c == 7) check("valid_before_T1", 32'(out_valid), 0);
        if (c == 8) begin
            check("valid_at_T1", 32'(out_valid), 1);
            check("frame0_num", 32'(out_frame), 0);
        end
        if (c >= 32 && c <= 51) begin
            if (!(out_valid === 1'b1 && out_ch === 4'd0 &&
                  out_data === 32'h30 && out_frame === 16'd3))
                unstable++;
        end
        if (c == 50) check("drop_bp", 32'(drop_cnt), 2);
        if (c == 51) check("bp_stable", 32'(unstable), 0);
        if (c == 56) begin
            check("simul_valid", 32'(out_valid), 1);
            check("simul_ch", 32'(out_ch), 0);
            check("simul_frame", 32'(out_frame), 6);
            check("simul_drop", 32'(drop_cnt), 2);
        end
        if (c == 80) begin
            check("p16_valid", 32'(out_valid), 1);
            check("p16_frame", 32'(out_frame), 8);
        end
        if (c == 84) begin
            check("p2_valid", 32'(out_valid), 1);
            check("p2_ch", 32'(out_ch), 0);
            check("p2_frame", 32'(out_frame), 10);
            check("p2_drop", 32'(drop_cnt), 3);
        end
        if (c == 92) begin
            check("p2_drop_end", 32'(drop_cnt), 4);
            check("en0_idle", 32'(out_valid), 0);
        end
        if (c == 104) begin
            check("rst_valid", 32'(out_valid), 0);
            check("rst_drop", 32'(drop_cnt), 0);
            check("rst_frame", 32'(out_frame), 0);
            check("rst_ch", 32'(out_ch), 0);
            check("rst_data", out_data, 0);
            check("rst_last", 32'(out_last), 0);
        end
        if (c == 113) begin
            check("post_rst_valid", 32'(out_valid), 1);
            check("post_rst_frame", 32'(out_frame), 0);
        end
    endtask

    initial begin
        rst        = 1'b1;
        en         = 1'b0;
        cfg_period = CW'(8);
        data_in    = '0;
        out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_valid", 32'(out_valid), 0);
        check("reset_data", out_data, 0);
        check("reset_ch", 32'(out_ch), 0);
        check("reset_last", 32'(out_last), 0);
        check("reset_frame", 32'(out_frame), 0);
        check("reset_drop", 32'(drop_cnt), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int c = 0; c < 121; c++) begin
            drive(c);
            @(negedge clk);
            check_cycle(c);
            @(posedge clk);
            #1;
        end
        check("queue_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
